// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_pkg
// Description : Shared types and constants for the motherboard SRAM arbiter
//               and the request arbiters reused by the UART/VGA blocks.
//               Contents: arb_state_t FSM encoding, arbitration mode
//               constants, default SRAM address/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package board_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

endpackage
`default_nettype wire

// File: rtl/board_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : board_rr_arbiter
// Description : Purely combinational request arbiter, fixed priority (lowest
//               index wins) or round-robin (search starts one past the last
//               grant, wrapping modulo N_PORTS).
// Ports       : req_i          per-port request
//               last_grant_i   index of the previously granted port
//               rr_mode_i      ARB_FIXED / ARB_RR
//               grant_valid_o  at least one request present
//               grant_oh_o     one-hot grant
//               grant_idx_o    grant index, upper bits zero
// Revision    : 1.0 - initial release
// ============================================================================
module board_rr_arbiter
  import board_pkg::*;
#(
  parameter int N_PORTS = 3
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [2:0]         last_grant_i,
  input  logic               rr_mode_i,
  output logic               grant_valid_o,
  output logic [N_PORTS-1:0] grant_oh_o,
  output logic [2:0]         grant_idx_o
);

  int start_idx;
  int cand;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_oh_o    = '0;
    grant_idx_o   = '0;
    start_idx     = 0;
    cand          = 0;
    if (rr_mode_i == ARB_RR) begin
      start_idx = (int'(last_grant_i) + 1) % N_PORTS;
    end
    // Walk the ports in priority order; the first requester found wins.
    for (int k = 0; k < N_PORTS; k++) begin
      cand = (start_idx + k) % N_PORTS;
      if (!grant_valid_o && req_i[cand]) begin
        grant_valid_o    = 1'b1;
        grant_oh_o[cand] = 1'b1;
        grant_idx_o      = 3'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/board_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : board_mem_arbiter
// Description : Multi-port arbiter in front of the shared external SRAM.
//               Grants one single-outstanding request at a time, runs a
//               wait-stated read or write cycle and returns a one-cycle ack
//               (plus read data for reads). The tristate pad lives above.
// Ports       : clk, rst (sync, active low)
//               req_i/we_i/addr_i/wdata_i  flattened per-port request bus
//               ack_o/rdata_o              per-port completion and read data
//               busy_o, cur_port_o         status
//               mem_addr_o, mem_dq_o, mem_dq_oe_o, mem_dq_i,
//               mem_ce_n_o, mem_oe_n_o, mem_we_n_o   SRAM pins
// Revision    : 1.0 - initial release
// ============================================================================
module board_mem_arbiter
  import board_pkg::*;
#(
  parameter int N_PORTS     = 3,
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int WAIT_STATES = 1,
  parameter int RR_MODE     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_i,
  input  logic [N_PORTS-1:0]        we_i,
  input  logic [N_PORTS*ADDR_W-1:0] addr_i,
  input  logic [N_PORTS*DATA_W-1:0] wdata_i,
  output logic [N_PORTS-1:0]        ack_o,
  output logic [N_PORTS*DATA_W-1:0] rdata_o,
  output logic                      busy_o,
  output logic [2:0]                cur_port_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_dq_o,
  output logic                      mem_dq_oe_o,
  input  logic [DATA_W-1:0]         mem_dq_i,
  output logic                      mem_ce_n_o,
  output logic                      mem_oe_n_o,
  output logic                      mem_we_n_o
);

  localparam int               CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WAIT_STATES);
  localparam logic [2:0]       LAST_RST = 3'(N_PORTS - 1);
  localparam logic             RR_SEL   = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  arb_state_t                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]         lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]         lat_wdata_q, lat_wdata_d;
  logic                      lat_we_q, lat_we_d;
  logic [2:0]                port_q, port_d;
  logic [2:0]                last_grant_q, last_grant_d;
  logic [N_PORTS-1:0]        ack_q, ack_d;
  logic [N_PORTS*DATA_W-1:0] rdata_q, rdata_d;
  logic                      busy_q, busy_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]         mem_dq_q, mem_dq_d;
  logic                      dq_oe_q, dq_oe_d;
  logic                      ce_n_q, ce_n_d;
  logic                      oe_n_q, oe_n_d;
  logic                      we_n_q, we_n_d;

  logic                      grant_valid;
  logic [N_PORTS-1:0]        grant_oh;
  logic [2:0]                grant_idx;
  logic [ADDR_W-1:0]         sel_addr;
  logic [DATA_W-1:0]         sel_wdata;
  logic                      sel_we;
  logic                      in_access;
  logic                      in_recover;

  board_rr_arbiter #(
    .N_PORTS (N_PORTS)
  ) u_arb (
    .req_i         (req_i),
    .last_grant_i  (last_grant_q),
    .rr_mode_i     (RR_SEL),
    .grant_valid_o (grant_valid),
    .grant_oh_o    (grant_oh),
    .grant_idx_o   (grant_idx)
  );

  // One-hot AND-OR mux of the winning port's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_oh[i]) begin
        sel_addr  = sel_addr  | addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | wdata_i[i*DATA_W +: DATA_W];
        sel_we    = sel_we    | we_i[i];
      end
    end
  end

  // Next-state logic: grant, wait counting and request latching.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_we_d     = lat_we_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_valid) begin
          state_d      = ACCESS;
          lat_addr_d   = sel_addr;
          lat_wdata_d  = sel_wdata;
          lat_we_d     = sel_we;
          port_d       = grant_idx;
          last_grant_d = grant_idx;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_MAX) begin
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are driven from the current state, so the pins trail
  // the FSM by one edge. The read data is therefore captured on the edge
  // where the FSM sits in RECOVER, which closes the last ACCESS pin cycle.
  always_comb begin
    in_access  = (state_q == ACCESS);
    in_recover = (state_q == RECOVER);
    busy_d     = (state_q != IDLE);
    mem_addr_d = in_access ? lat_addr_q : mem_addr_q;
    mem_dq_d   = (in_access && lat_we_q) ? lat_wdata_q : mem_dq_q;
    dq_oe_d    = (in_access || in_recover) && lat_we_q;
    ce_n_d     = !(in_access || in_recover);
    oe_n_d     = !(in_access && !lat_we_q);
    we_n_d     = !(in_access && lat_we_q);
    ack_d      = '0;
    rdata_d    = rdata_q;
    for (int i = 0; i < N_PORTS; i++) begin
      if (in_recover && (port_q == 3'(i))) begin
        ack_d[i] = 1'b1;
        if (!lat_we_q) begin
          rdata_d[i*DATA_W +: DATA_W] = mem_dq_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      lat_we_q     <= 1'b0;
      port_q       <= '0;
      last_grant_q <= LAST_RST;
      ack_q        <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_dq_q     <= '0;
      dq_oe_q      <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_we_q     <= lat_we_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_dq_q     <= mem_dq_d;
      dq_oe_q      <= dq_oe_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
    end
  end

  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = busy_q;
  assign cur_port_o  = port_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_dq_o    = mem_dq_q;
  assign mem_dq_oe_o = dq_oe_q;
  assign mem_ce_n_o  = ce_n_q;
  assign mem_oe_n_o  = oe_n_q;
  assign mem_we_n_o  = we_n_q;

endmodule
`default_nettype wire

// File: tb/tb_board_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_mem_arbiter
// Description : Directed self-checking bench for board_mem_arbiter. Three
//               instances: main (WS=1, RR), fixed-priority (WS=1), and
//               zero-wait round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // ---------------- main instance: WAIT_STATES=1, round-robin -------------
  logic [N-1:0]    req, we, ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata, rdata;
  logic            busy, dq_oe, ce_n, oe_n, we_n;
  logic [2:0]      cur_port;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   dq_o, dq_i;
  logic [DW-1:0]   sram [0:(1<<AW)-1];

  assign dq_i = (!ce_n && !oe_n) ? sram[mem_addr] : '0;
  always @(posedge clk) begin
    if (!rst)                sram[18'h00010] <= 16'hBEEF;
    else if (!ce_n && !we_n) sram[mem_addr]  <= dq_o;
  end

  board_mem_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(1), .RR_MODE(1)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack), .rdata_o(rdata), .busy_o(busy), .cur_port_o(cur_port),
    .mem_addr_o(mem_addr), .mem_dq_o(dq_o), .mem_dq_oe_o(dq_oe), .mem_dq_i(dq_i),
    .mem_ce_n_o(ce_n), .mem_oe_n_o(oe_n), .mem_we_n_o(we_n)
  );

  // ---------------- fixed-priority instance ------------------------------
  logic [N-1:0]    fx_req, fx_ack;
  logic [N*DW-1:0] fx_rdata;
  logic            fx_busy, fx_dq_oe, fx_ce_n, fx_oe_n, fx_we_n;
  logic [2:0]      fx_cur_port;
  logic [AW-1:0]   fx_mem_addr;
  logic [DW-1:0]   fx_dq_o;

  board_mem_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(1), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .req_i(fx_req), .we_i({N{1'b0}}), .addr_i({(N*AW){1'b0}}),
    .wdata_i({(N*DW){1'b0}}), .ack_o(fx_ack), .rdata_o(fx_rdata), .busy_o(fx_busy),
    .cur_port_o(fx_cur_port), .mem_addr_o(fx_mem_addr), .mem_dq_o(fx_dq_o),
    .mem_dq_oe_o(fx_dq_oe), .mem_dq_i({DW{1'b0}}), .mem_ce_n_o(fx_ce_n),
    .mem_oe_n_o(fx_oe_n), .mem_we_n_o(fx_we_n)
  );

  // ---------------- zero-wait instance -----------------------------------
  logic [N-1:0]    w0_req, w0_ack;
  logic [N*AW-1:0] w0_addr;
  logic [N*DW-1:0] w0_rdata;
  logic            w0_busy, w0_dq_oe, w0_ce_n, w0_oe_n, w0_we_n;
  logic [2:0]      w0_cur_port;
  logic [AW-1:0]   w0_mem_addr;
  logic [DW-1:0]   w0_dq_o, w0_dq_i, w0_cnt;

  // Model returns a new value for every completed access.
  assign w0_dq_i = (!w0_ce_n && !w0_oe_n) ? (16'hA000 + w0_cnt) : '0;
  always @(posedge clk) begin
    if (!rst)           w0_cnt <= '0;
    else if (w0_ack[1]) w0_cnt <= w0_cnt + 16'd1;
  end

  board_mem_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0), .RR_MODE(1)) dut_w0 (
    .clk(clk), .rst(rst), .req_i(w0_req), .we_i({N{1'b0}}), .addr_i(w0_addr),
    .wdata_i({(N*DW){1'b0}}), .ack_o(w0_ack), .rdata_o(w0_rdata), .busy_o(w0_busy),
    .cur_port_o(w0_cur_port), .mem_addr_o(w0_mem_addr), .mem_dq_o(w0_dq_o),
    .mem_dq_oe_o(w0_dq_oe), .mem_dq_i(w0_dq_i), .mem_ce_n_o(w0_ce_n),
    .mem_oe_n_o(w0_oe_n), .mem_we_n_o(w0_we_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({ack, busy, cur_port} !== 7'b0) begin
      errors++; $display("FAIL reset_status: ack/busy/cur_port got %b want 0", {ack, busy, cur_port});
    end
    checks++;
    if (rdata !== '0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", rdata);
    end
    checks++;
    if ({mem_addr, dq_o, dq_oe} !== '0) begin
      errors++; $display("FAIL reset_pins: addr %h dq %h oe %b want all 0", mem_addr, dq_o, dq_oe);
    end
    checks++;
    if ({ce_n, oe_n, we_n} !== 3'b111) begin
      errors++; $display("FAIL reset_strobes: got %b want 111", {ce_n, oe_n, we_n});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    req = 3'b001; we = 3'b000; addr[0 +: AW] = 18'h00010;
    tick();
    req = 3'b000; addr = '0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (oe_n !== ((c <= 2) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL read_oe_n c%0d: got %b want %b", c, oe_n, (c <= 2) ? 1'b0 : 1'b1);
      end
      checks++;
      if (ack !== ((c == 3) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL read_ack c%0d: got %b want %b", c, ack, (c == 3) ? 3'b001 : 3'b000);
      end
      if (c == 1) begin
        checks++;
        if ({mem_addr, ce_n, busy} !== {18'h00010, 1'b0, 1'b1}) begin
          errors++; $display("FAIL read_pins: addr %h ce_n %b busy %b want 00010 0 1", mem_addr, ce_n, busy);
        end
      end
    end
    checks++;
    if (rdata[0 +: DW] !== 16'hBEEF) begin
      errors++; $display("FAIL read_rdata0: got %h want beef", rdata[0 +: DW]);
    end
    checks++;
    if (rdata[DW +: 2*DW] !== '0) begin
      errors++; $display("FAIL read_rdata12: got %h want 0", rdata[DW +: 2*DW]);
    end
  endtask

  task automatic test_single_write();
    int acks = 0;
    req = 3'b100; we = 3'b100; addr[2*AW +: AW] = 18'h3FFFF; wdata[2*DW +: DW] = 16'h1234;
    tick();
    req = '0; we = '0; addr = '0; wdata = '0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (we_n !== ((c <= 2) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL write_we_n c%0d: got %b", c, we_n);
      end
      checks++;
      if (dq_oe !== ((c <= 3) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL write_dq_oe c%0d: got %b", c, dq_oe);
      end
      if (ack[2]) acks++;
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL write_ack_count: got %0d want 1", acks);
    end
    checks++;
    if (sram[18'h3FFFF] !== 16'h1234) begin
      errors++; $display("FAIL write_mem: got %h want 1234", sram[18'h3FFFF]);
    end
  endtask

  task automatic test_fixed_priority();
    int n0 = 0;
    int nother = 0;
    fx_req = 3'b111;
    tick();
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (fx_ack[0]) n0++;
      if (fx_ack[2:1] != 2'b00) nother++;
      if (c == 15) fx_req = 3'b000;
    end
    checks++;
    if (n0 != 4) begin
      errors++; $display("FAIL fixed_port0_acks: got %0d want 4", n0);
    end
    checks++;
    if (nother != 0) begin
      errors++; $display("FAIL fixed_other_acks: got %0d want 0", nother);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_oh [6];
    int n = 0;
    exp_oh = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    req = 3'b111; we = 3'b000;
    addr = {18'h00102, 18'h00101, 18'h00100};
    tick();
    for (int c = 1; c <= 28; c++) begin
      tick();
      if (ack != 3'b000) begin
        checks++;
        if (n >= 6 || ack !== exp_oh[n]) begin
          errors++; $display("FAIL rr_order n%0d: got %b want %b", n, ack, (n < 6) ? exp_oh[n] : 3'b000);
        end
        checks++;
        if (c != 3 + 4*n) begin
          errors++; $display("FAIL rr_spacing n%0d: cycle %0d want %0d", n, c, 3 + 4*n);
        end
        n++;
      end
      if (c == 23) req = 3'b000;
    end
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL rr_ack_count: got %0d want 6", n);
    end
    addr = '0;
  endtask

  task automatic test_reset_mid_access();
    req = 3'b010; we = 3'b010; addr[AW +: AW] = 18'h00055; wdata[DW +: DW] = 16'hDEAD;
    tick();
    req = '0; we = '0; addr = '0; wdata = '0;
    tick();
    checks++;
    if (we_n !== 1'b0) begin
      errors++; $display("FAIL rst_pre_we_n: got %b want 0", we_n);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({ce_n, oe_n, we_n, dq_oe, ack} !== {3'b111, 1'b0, 3'b000}) begin
      errors++; $display("FAIL rst_abort: strobes %b oe %b ack %b want 111 0 000", {ce_n, oe_n, we_n}, dq_oe, ack);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ack, busy} !== 4'b0000) begin
      errors++; $display("FAIL rst_no_ack: ack %b busy %b want 000 0", ack, busy);
    end
    req = 3'b111;
    tick();
    req = 3'b000;
    checks++;
    if (cur_port !== 3'd0) begin
      errors++; $display("FAIL rst_first_grant: got %0d want 0", cur_port);
    end
    tick(); tick(); tick();
    checks++;
    if (ack !== 3'b001) begin
      errors++; $display("FAIL rst_first_ack: got %b want 001", ack);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    w0_req = 3'b010; w0_addr[AW +: AW] = 18'h00020;
    tick();
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (w0_ack != 3'b000) begin
        checks++;
        if (w0_ack !== 3'b010 || c != 2 + 3*n) begin
          errors++; $display("FAIL b2b_ack n%0d: ack %b cycle %0d want 010 at %0d", n, w0_ack, c, 2 + 3*n);
        end
        checks++;
        if (w0_rdata[DW +: DW] !== 16'hA000 + 16'(n)) begin
          errors++; $display("FAIL b2b_rdata n%0d: got %h want %h", n, w0_rdata[DW +: DW], 16'hA000 + 16'(n));
        end
        n++;
      end
      if (c == 11) w0_req = 3'b000;
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL b2b_ack_count: got %0d want 4", n);
    end
    checks++;
    if ({w0_rdata[0 +: DW], w0_rdata[2*DW +: DW]} !== 32'h0) begin
      errors++; $display("FAIL b2b_other_rdata: got %h want 0", {w0_rdata[0 +: DW], w0_rdata[2*DW +: DW]});
    end
  endtask

  initial begin
    rst = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    fx_req = '0;
    w0_req = '0; w0_addr = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_fixed_priority();
    test_round_robin();
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Parametrised multi-port arbiter between on-board requesters and the shared external SRAM: CPU instruction fetch, CPU data access, graphics read-out, UART DMA, and so on. Each port presents a single-outstanding request/acknowledge transaction. The block grants one request at a time, using either fixed-priority or round-robin policy. It then runs a wait-stated SRAM read or write cycle and returns the acknowledge, plus read data for reads. It sits in the motherboard top level between the CPU/peripheral ports and the SRAM pins; the top level owns the tristate buffer.

## Interface
- N_PORTS, 3: number of requesters, 1..8
- ADDR_W, 18: SRAM address width
- DATA_W, 16: SRAM data width
- WAIT_STATES, 1: extra access cycles, 0..15
- RR_MODE, 1: 0 = fixed priority, lowest index wins; 1 = round-robin
- clk  in  1  single board clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req  in  N_PORTS  per-port request level
- we  in  N_PORTS  per-port 1 = write, 0 = read
- addr  in  N_PORTS*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_PORTS*DATA_W  port i at [i*DATA_W +: DATA_W]
- ack  out  N_PORTS  one-cycle completion pulse
- rdata  out  N_PORTS*DATA_W  per-port read-data register
- busy  out  1  access in progress (state != IDLE)
- cur_port  out  3  index of the granted or last granted port
- mem_addr  out  ADDR_W  SRAM address
- mem_dq_o  out  DATA_W  write data to the pad
- mem_dq_oe  out  1  pad output enable
- mem_dq_i  in  DATA_W  data read from the pad
- mem_ce_n, mem_oe_n, mem_we_n  out  1 each  active-low SRAM strobes

## Operation
- **FSM states:** IDLE, ACCESS, RECOVER.
- **IDLE:**
  - If any `req` is high, pick grant `g`.
  - Latch `addr[g]`, `wdata[g]`, `we[g]` and `g` into internal registers.
  - Clear the wait counter and go to ACCESS.
  - If no `req` is high, stay in IDLE.
- **ACCESS:** lasts WAIT_STATES+1 cycles.
  - `mem_ce_n` = 0; `mem_addr` = latched address.
  - Read: `mem_oe_n` = 0. On the final ACCESS cycle, sample `mem_dq_i` into the read holding register.
  - Write: `mem_we_n` = 0, `mem_dq_oe` = 1, `mem_dq_o` = latched wdata.
- **RECOVER:** exactly one cycle, then IDLE.
  - `mem_ce_n` stays 0 and `mem_we_n`/`mem_oe_n` = 1.
  - For writes, `mem_dq_oe` stays 1 (data hold time).
  - `ack[g]` = 1.
  - For reads, `rdata[g]` is updated this cycle and holds until that port's next read completes. Other ports' `rdata` are untouched.
- **Arbitration:**
  - Fixed mode: lowest set index wins.
  - Round-robin mode: search starts at `last_grant+1` modulo N_PORTS, and `last_grant` updates at grant. Reset value of `last_grant` is N_PORTS-1, so port 0 wins first.
- **Requester rule:**
  - `req` is sampled only in IDLE.
  - `addr`/`we`/`wdata` need only be valid in the grant cycle.
  - `req` still high in the IDLE cycle after `ack` counts as a new request.
  - Dropping `req` mid-access does not abort; `ack` is still issued.
- **Idle pin state:** `mem_addr` holds its last value; all strobes are 1.
- **Reset values:**
  - `ack` = 0, `rdata` = 0, `busy` = 0, `cur_port` = 0, `mem_addr` = 0.
  - `mem_dq_o` = 0, `mem_dq_oe` = 0, `mem_ce_n` = `mem_oe_n` = `mem_we_n` = 1.
  - FSM = IDLE.
- **Reset mid-access:** the access is aborted, no `ack` is issued, and the strobes go inactive on the next edge.

## Timing
- Request high in IDLE at edge 0 → ACCESS from edge 1 → RECOVER/`ack` at edge WAIT_STATES+2 → IDLE at edge WAIT_STATES+3.
- Read-to-ack latency: WAIT_STATES+2 cycles. Peak throughput: one access per WAIT_STATES+3 cycles.
- All outputs are registered; no combinational path from `req` to the SRAM pins or to `ack`.
- Wait counter width is `max(1, $clog2(WAIT_STATES+1))`. The counter saturates at WAIT_STATES and is cleared in IDLE.
- `cur_port` width is fixed at 3; unused upper bits are 0.

## Structure
- **Shared package `board_pkg`:**
  - State enum `arb_state_t` {IDLE, ACCESS, RECOVER}.
  - Mode constants `ARB_FIXED` = 0, `ARB_RR` = 1.
  - Default SRAM widths (18/16).
- **Sub-module `board_rr_arbiter`:**
  - Inputs: `req`, `last_grant`, mode.
  - Outputs: `grant_valid` and one-hot/index grant.
  - Purely combinational, so it can be reused by the UART/VGA blocks.
- **Top FSM, counter and latches:** live in `board_mem_arbiter`.

## Test plan
1. **Single read:** WAIT_STATES=1; `req[0]` read at addr 0x00010; SRAM model returns 0xBEEF. Expect:
   - `mem_oe_n` = 0 for 2 cycles.
   - `ack[0]` at cycle 3 and `rdata[0]` = 0xBEEF.
   - `rdata[1..2]` remain 0.
2. **Single write:** `req[2]` write 0x1234 to 0x3FFFF. Expect:
   - `mem_we_n` low for 2 cycles.
   - `mem_dq_oe` high through RECOVER.
   - Model holds 0x1234 at 0x3FFFF; `ack[2]` pulses once.
3. **Fixed priority:** RR_MODE=0; `req` = 3'b111 held high. Expect every grant to port 0 and ports 1/2 never acked.
4. **Round-robin:** RR_MODE=1; `req` = 3'b111 held high. Expect grant order 0, 1, 2, 0, 1, 2, with acks spaced WAIT_STATES+3 cycles apart.
5. **Reset mid-access:** assert `rst` = 0 during ACCESS of a write. Expect:
   - Next edge: strobes = 1, `mem_dq_oe` = 0, no `ack`.
   - After release, port 0 wins first.
6. **WAIT_STATES=0 back-to-back:** `req[1]` read held high. Expect `ack[1]` every 3 cycles with `rdata[1]` tracking successive model values.
